ro_puf_pair_counter: RTL
========================

// Module: ro_puf_pair_counter
// PURPOSE
//   Parametrised ring-oscillator PUF evaluator; successor to the fixed 16-RO counter group.
//   A challenge selects two of N_RO free-running RO outputs. Each is synchronised and its
//   rising edges are counted over a fixed window of system-clock cycles. The two counts are
//   then compared to give one response bit.
//   Sits between the RO array and the challenge/response controller; start/busy/done handshake.
// PARAMETERS
//   N_RO        16  number of ring-oscillator inputs
//   SEL_W       4   challenge index width; must equal $clog2(N_RO)
//   CNT_W       8   width of each edge counter; counters saturate, never wrap
//   WINDOW      64  measurement window length in clk cycles (>=1)
//   SYNC_STAGES 2   flip-flop stages in each RO input synchroniser (>=2)
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   reset      in   1      synchronous, active-high reset
//   start      in   1      request evaluation; sampled only in IDLE
//   cha0       in   SEL_W  index of first RO; latched on accepted start
//   cha1       in   SEL_W  index of second RO; latched on accepted start
//   ro_in      in   N_RO   asynchronous RO outputs
//   busy       out  1      evaluation in progress
//   done       out  1      one-cycle pulse: results valid
//   response   out  1      1 when cnt0 > cnt1
//   tie        out  1      1 when cnt0 == cnt1
//   sat        out  1      1 when either counter saturated during the window
//   cnt0       out  CNT_W  final edge count of RO[cha0]
//   cnt1       out  CNT_W  final edge count of RO[cha1]
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, response, tie, sat = 0; cnt0, cnt1 = 0.
//     Synchronisers and edge-history registers are cleared.
//   Reset mid-operation: abandon the evaluation and return to IDLE on the next cycle.
//     All outputs read 0; no done pulse is issued.
//   Synchroniser: every ro_in bit passes through SYNC_STAGES flops.
//     Edge detection uses one extra history flop per selected channel.
//     Rising edge = (sync==1 && hist==0).
//     RO frequency must be < clk/2; faster inputs alias, and this is not flagged.
//   FSM: IDLE -> SETTLE -> COUNT -> COMPARE -> DONE -> IDLE.
//     IDLE: if start==1, latch cha0/cha1, clear counters and sat, go to SETTLE.
//     SETTLE: lasts S = SYNC_STAGES+1 cycles to flush the synchronisers and load the
//       history flops. No counting, so no spurious edge can be counted at window open.
//     COUNT: lasts exactly WINDOW cycles. Each detected rising edge adds 1 to its counter.
//       At all-ones the counter holds and sets sat.
//     COMPARE: 1 cycle. response = (cnt0 > cnt1); tie = (cnt0 == cnt1). Comparison is unsigned.
//     DONE: done=1 for one cycle, then IDLE.
//   Timing: start sampled at cycle t -> busy=1 during t+1 .. t+S+WINDOW+1.
//     done=1 (busy=0) at t+S+WINDOW+2; with defaults this is t+69.
//   Outputs response/tie/sat/cnt0/cnt1 become valid in the done cycle.
//     They hold until the next accepted start, which clears them at t+1.
//   start while busy or during DONE: ignored; challenges are not re-latched.
//   cha0 == cha1: legal. Counts are equal, so tie=1 and response=0.
//   Only the latched channels are counted; activity on other ro_in bits has no effect.
//   Challenge inputs may change freely after start is accepted.
// TESTING
//   1 reset held 3 cycles -> busy=done=response=tie=sat=0, cnt0=cnt1=0.
//   2 cha0=4'b1100, cha1=4'b1000; ro_in[12] period 4clk, ro_in[8] period 8clk, start @t
//     -> done @t+69; cnt0=16, cnt1=8, response=1, tie=0, sat=0.
//   3 same stimulus with cha0/cha1 swapped -> cnt0=8, cnt1=16, response=0, tie=0.
//   4 cha0=cha1=5, ro_in[5] period 4 -> cnt0=cnt1=16, tie=1, response=0.
//     Toggling all other ro_in bits changes nothing.
//   5 instance with CNT_W=3; ro_in[12] period 4, ro_in[8] static
//     -> cnt0=7, sat=1, cnt1=0, response=1.
//   6a reset pulsed at t+30 of an evaluation -> IDLE at t+31, all outputs 0, no done.
//   6b start re-asserted during COUNT -> ignored; done still lands at t+69.

Source files
------------

// File: rtl/ro_puf_pair_counter.sv
// Ring-oscillator PUF pair evaluator: synchronises N_RO ring-oscillator inputs, counts the rising
// edges of two challenge-selected channels over a fixed window, and compares the two counts.
module ro_puf_pair_counter #(
  parameter int N_RO        = 16,
  parameter int SEL_W       = 4,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] cha0,
  input  logic [SEL_W-1:0] cha1,
  input  logic [N_RO-1:0]  ro_in,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic             sat,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [2:0]       o_dbg_state
);

  localparam int S     = SYNC_STAGES + 1;
  localparam int TMR_W = $clog2(((WINDOW > S) ? WINDOW : S) + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COUNT   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e             r_state;
  state_e             w_state_nx;
  logic               w_phase_end;
  logic [TMR_W-1:0]   r_tmr;
  logic [N_RO-1:0]    r_sync [SYNC_STAGES];
  logic [SEL_W-1:0]   r_cha0;
  logic [SEL_W-1:0]   r_cha1;
  logic               r_hist0;
  logic               r_hist1;
  logic               w_s0;
  logic               w_s1;
  logic               w_edge0;
  logic               w_edge1;
  logic               w_max0;
  logic               w_max1;
  logic [CNT_W-1:0]   r_cnt0;
  logic [CNT_W-1:0]   r_cnt1;
  logic               r_sat;
  logic               r_response;
  logic               r_tie;

  // Every RO bit is synchronised continuously, so a new challenge sees settled data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= ro_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s0    = r_sync[SYNC_STAGES-1][r_cha0];
  assign w_s1    = r_sync[SYNC_STAGES-1][r_cha1];
  assign w_edge0 = (r_state == ST_COUNT) && w_s0 && !r_hist0;
  assign w_edge1 = (r_state == ST_COUNT) && w_s1 && !r_hist1;
  assign w_max0  = &r_cnt0;
  assign w_max1  = &r_cnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist0 <= 1'b0;
      r_hist1 <= 1'b0;
    end else begin
      r_hist0 <= w_s0;
      r_hist1 <= w_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_phase_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_phase_end = (r_tmr == TMR_W'(S - 1));
        if (w_phase_end) w_state_nx = ST_COUNT;
      end
      ST_COUNT: begin
        w_phase_end = (r_tmr == TMR_W'(WINDOW - 1));
        if (w_phase_end) w_state_nx = ST_COMPARE;
      end
      ST_COMPARE: w_state_nx = ST_DONE;
      ST_DONE:    w_state_nx = ST_IDLE;
      default:    w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmr      <= '0;
      r_cha0     <= '0;
      r_cha1     <= '0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
      r_sat      <= 1'b0;
      r_response <= 1'b0;
      r_tie      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmr <= '0;
          if (start) begin
            r_cha0     <= cha0;
            r_cha1     <= cha1;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
            r_sat      <= 1'b0;
            r_response <= 1'b0;
            r_tie      <= 1'b0;
          end
        end
        ST_SETTLE: begin
          r_tmr <= w_phase_end ? '0 : r_tmr + 1'b1;
        end
        ST_COUNT: begin
          r_tmr <= w_phase_end ? '0 : r_tmr + 1'b1;
          // A counter at all-ones holds; the edge it would have wrapped on raises sat.
          if (w_edge0 && !w_max0) r_cnt0 <= r_cnt0 + 1'b1;
          if (w_edge1 && !w_max1) r_cnt1 <= r_cnt1 + 1'b1;
          if ((w_edge0 && w_max0) || (w_edge1 && w_max1)) r_sat <= 1'b1;
        end
        ST_COMPARE: begin
          r_response <= (r_cnt0 > r_cnt1);
          r_tie      <= (r_cnt0 == r_cnt1);
        end
        default: r_tmr <= '0;
      endcase
    end
  end

  assign busy        = (r_state == ST_SETTLE) || (r_state == ST_COUNT) || (r_state == ST_COMPARE);
  assign done        = (r_state == ST_DONE);
  assign response    = r_response;
  assign tie         = r_tie;
  assign sat         = r_sat;
  assign cnt0        = r_cnt0;
  assign cnt1        = r_cnt1;
  assign o_dbg_state = r_state;

endmodule
